config_sequencer: RTL and testbench
===================================

Name: config_sequencer

Overview:
- Sequenced front end for the multi-dataflow configurator.
- Accepts configuration-ID requests over a valid/ready handshake, stalls the merged datapath's input, and waits for the datapath to drain.
- Then drives the switch-box select vector and releases the stall.
- Sits between the host/control interface and the merged datapath's sbox select inputs; replaces direct, unsequenced ID→sel decoding.

Parameters:
- ID_W, 8, width of configuration ID.
- SEL_W, 2, width of switch-box select vector.
- SEL_CFG1, 2'b00, select vector for ID 1.
- SEL_CFG2, 2'b11, select vector for ID 2.
- DRAIN_CYCLES, 4, consecutive idle cycles required before switching; must be ≥1.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  configuration request valid.
- req_id  in  ID_W  requested configuration ID.
- req_ready  out  1  request accepted when req_valid & req_ready at a clock edge.
- dp_busy  in  1  datapath has tokens in flight.
- stall  out  1  gates datapath input actors; registered.
- sel  out  SEL_W  switch-box select vector; registered.
- cfg_id  out  ID_W  currently applied ID; 0 = none.
- cfg_valid  out  1  a configuration is applied.
- switch_done  out  1  one-cycle pulse when a new or repeated configuration becomes active.
- err  out  1  one-cycle pulse when an unknown ID is accepted.

Behaviour:
- Reset values (synchronous reset; takes priority over all else, in any state including mid-DRAIN/APPLY):
  - state=IDLE, sel=0, cfg_id=0, cfg_valid=0, stall=1, switch_done=0, err=0, drain counter=0.
- ID decode: 1→SEL_CFG1, 2→SEL_CFG2; any other value is unknown.
- req_ready = 1 in IDLE and RUN, 0 in DRAIN and APPLY (combinational from state). Requests held during DRAIN/APPLY are neither dropped nor accepted until req_ready returns.
- IDLE (stall=1):
  - Known ID accepted at edge k → APPLY at k; sel/cfg_id loaded at k.
  - Then RUN at k+1 with stall=0, cfg_valid=1, switch_done=1 for that cycle.
- RUN (stall=0):
  - Known ID ≠ cfg_id accepted → DRAIN, stall=1 at same edge, counter=0.
  - Known ID = cfg_id → stay RUN, no stall, switch_done pulses next cycle.
- DRAIN (stall=1):
  - Each edge: dp_busy=1 → counter=0; dp_busy=0 → counter+1.
  - When counter==DRAIN_CYCLES-1 and dp_busy=0 → APPLY; sel and cfg_id loaded at that edge.
  - No timeout; DRAIN holds indefinitely while dp_busy toggles.
- APPLY (stall=1, one cycle) → RUN; stall=0, switch_done=1 in first RUN cycle.
- Unknown ID accepted in IDLE or RUN: state, sel, cfg_id unchanged; err=1 for exactly the next cycle.
- Latency with DRAIN_CYCLES=4, dp_busy=0:
  - accept at edge 0 → sel changes at edge 4 → stall falls at edge 5.
- sel and cfg_id change only on an APPLY transition or reset; never glitch otherwise.
- Counter width: ceil(log2(DRAIN_CYCLES+1)); saturation not needed.

Test Plan:
- Reset, no stimulus → sel=00, cfg_id=0, cfg_valid=0, stall=1, req_ready=1, switch_done=0, err=0.
- IDLE, req_id=1 accepted at edge 0 → sel=00 and cfg_id=1 at edge 0; stall=0, cfg_valid=1, switch_done=1 at edge 1 only.
- RUN cfg 1, dp_busy=0, req_id=2 at edge 0 → stall=1 at 0, req_ready=0 edges 0–4, sel=11 at 4, stall=0 and switch_done=1 at 5.
- Same switch with dp_busy=1 at edge 2 then 0 → counter restarts; sel=11 at edge 6, stall=0 at 7.
- RUN cfg 2, req_id=7 → err=1 one cycle, sel stays 11, cfg_id stays 2, stall stays 0. Then req_id=2 → switch_done=1 next cycle, no stall.
- Reset asserted during DRAIN (edge 2 of switch 1→2) → next cycle all outputs equal reset values; sel=00, cfg_valid=0.

Source files
------------

// File: rtl/config_sequencer.sv
// config_sequencer: sequenced front end for the multi-dataflow configurator.
// Accepts configuration-ID requests over a valid/ready handshake. It stalls the
// datapath input and waits for the datapath to drain before it switches the
// switch-box select vector and releases the stall.
//
// Ports:
//   clock        single system clock; all logic on the rising edge
//   reset        synchronous, active-high reset
//   req_valid    configuration request valid
//   req_id       requested configuration ID
//   req_ready    request accepted on req_valid & req_ready at a clock edge
//   dp_busy      datapath has tokens in flight
//   stall        gates the datapath input actors (registered)
//   sel          switch-box select vector (registered)
//   cfg_id       currently applied ID; 0 means none
//   cfg_valid    a configuration is applied
//   switch_done  one-cycle pulse when a new or repeated configuration is active
//   err          one-cycle pulse when an unknown ID is accepted
module config_sequencer #(
    parameter int                ID_W         = 8,
    parameter int                SEL_W        = 2,
    parameter logic [SEL_W-1:0]  SEL_CFG1     = 2'b00,
    parameter logic [SEL_W-1:0]  SEL_CFG2     = 2'b11,
    parameter int                DRAIN_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [ID_W-1:0]  req_id,
    output logic             req_ready,
    input  logic             dp_busy,
    output logic             stall,
    output logic [SEL_W-1:0] sel,
    output logic [ID_W-1:0]  cfg_id,
    output logic             cfg_valid,
    output logic             switch_done,
    output logic             err
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        APPLY
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [ID_W-1:0]    pend_id;
    logic [SEL_W-1:0]   pend_sel;

    logic               known;
    logic [SEL_W-1:0]   dec_sel;
    logic               accept;

    always_comb begin
        known   = 1'b0;
        dec_sel = '0;
        if (req_id == ID_W'(1)) begin
            known   = 1'b1;
            dec_sel = SEL_CFG1;
        end else if (req_id == ID_W'(2)) begin
            known   = 1'b1;
            dec_sel = SEL_CFG2;
        end
    end

    assign req_ready = (state == IDLE) || (state == RUN);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            pend_id     <= '0;
            pend_sel    <= '0;
            sel         <= '0;
            cfg_id      <= '0;
            cfg_valid   <= 1'b0;
            stall       <= 1'b1;
            switch_done <= 1'b0;
            err         <= 1'b0;
        end else begin
            switch_done <= 1'b0;
            err         <= 1'b0;
            case (state)
                IDLE: begin
                    // Nothing is flowing yet, so a first configuration
                    // can be applied without draining.
                    if (accept) begin
                        if (known) begin
                            state  <= APPLY;
                            sel    <= dec_sel;
                            cfg_id <= req_id;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (!known) begin
                            err <= 1'b1;
                        end else if (req_id == cfg_id) begin
                            switch_done <= 1'b1;
                        end else begin
                            state    <= DRAIN;
                            stall    <= 1'b1;
                            cnt      <= '0;
                            pend_id  <= req_id;
                            pend_sel <= dec_sel;
                        end
                    end
                end
                DRAIN: begin
                    // Any busy cycle restarts the idle-run count.
                    if (dp_busy) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= APPLY;
                        sel    <= pend_sel;
                        cfg_id <= pend_id;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                APPLY: begin
                    state       <= RUN;
                    stall       <= 1'b0;
                    cfg_valid   <= 1'b1;
                    switch_done <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    stall <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_sequencer.sv
// tb_config_sequencer: self-checking bench for config_sequencer.
// Directed timing checks plus a scoreboard of expected switch/err events.
module tb_config_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [7:0] req_id = '0;
    logic       req_ready;
    logic       dp_busy = 1'b0;
    logic       stall;
    logic [1:0] sel;
    logic [7:0] cfg_id;
    logic       cfg_valid;
    logic       switch_done;
    logic       err;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [7:0] id;
        logic [1:0] sel;
    } exp_t;

    exp_t sb[$];
    int   eq[$];

    config_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_id      (req_id),
        .req_ready   (req_ready),
        .dp_busy     (dp_busy),
        .stall       (stall),
        .sel         (sel),
        .cfg_id      (cfg_id),
        .cfg_valid   (cfg_valid),
        .switch_done (switch_done),
        .err         (err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] dec(input logic [7:0] id);
        return (id == 8'd2) ? 2'b11 : 2'b00;
    endfunction

    // Scoreboard producer: record what each accepted request must cause.
    always @(posedge clock) begin
        if (reset) begin
            sb.delete();
            eq.delete();
        end else if (req_valid && req_ready) begin
            if (req_id == 8'd1 || req_id == 8'd2)
                sb.push_back('{id: req_id, sel: dec(req_id)});
            else
                eq.push_back(int'(req_id));
        end
    end

    // Scoreboard consumer: each pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (!reset) begin
            if (switch_done) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_cfg_id", 32'(cfg_id), 32'(e.id));
                    chk("sb_sel", 32'(sel), 32'(e.sel));
                    chk("sb_stall", 32'(stall), 32'd0);
                    chk("sb_cfg_valid", 32'(cfg_valid), 32'd1);
                end
            end
            if (err) begin
                chk("err_underflow", 32'(eq.size() > 0), 32'd1);
                if (eq.size() > 0) void'(eq.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!switch_done && k < 200) begin
            step();
            k++;
        end
        chk(tag, 32'(switch_done), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sel"}, 32'(sel), 32'd0);
        chk({tag, "_cfg_id"}, 32'(cfg_id), 32'd0);
        chk({tag, "_cfg_valid"}, 32'(cfg_valid), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd1);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_switch_done"}, 32'(switch_done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        // Reset state.
        repeat (3) step();
        reset = 1'b0;
        chk_reset_vals("rst");

        // Unknown ID in IDLE: err pulse, stays IDLE.
        req_valid = 1'b1; req_id = 8'd0;
        step();
        req_valid = 1'b0;
        chk("idle_unk_err", 32'(err), 32'd1);
        chk("idle_unk_stall", 32'(stall), 32'd1);
        step();
        chk("idle_unk_err_off", 32'(err), 32'd0);
        chk("idle_unk_ready", 32'(req_ready), 32'd1);

        // IDLE -> cfg 1.
        req_valid = 1'b1; req_id = 8'd1;
        step();
        req_valid = 1'b0;
        chk("i1_sel", 32'(sel), 32'd0);
        chk("i1_cfg_id", 32'(cfg_id), 32'd1);
        chk("i1_stall_e0", 32'(stall), 32'd1);
        chk("i1_ready_e0", 32'(req_ready), 32'd0);
        chk("i1_done_e0", 32'(switch_done), 32'd0);
        step();
        chk("i1_stall_e1", 32'(stall), 32'd0);
        chk("i1_valid_e1", 32'(cfg_valid), 32'd1);
        chk("i1_done_e1", 32'(switch_done), 32'd1);
        step();
        chk("i1_done_e2", 32'(switch_done), 32'd0);

        // 1 -> 2, dp idle, request held through the drain.
        req_valid = 1'b1; req_id = 8'd2;
        step();
        chk("s12_stall_e0", 32'(stall), 32'd1);
        for (int e = 0; e <= 4; e++) begin
            if (e > 0) step();
            chk("s12_ready", 32'(req_ready), 32'd0);
            chk("s12_sel", 32'(sel), (e == 4) ? 32'd3 : 32'd0);
            chk("s12_stall", 32'(stall), 32'd1);
        end
        chk("s12_cfg_id_e4", 32'(cfg_id), 32'd2);
        step();
        req_valid = 1'b0;
        chk("s12_stall_e5", 32'(stall), 32'd0);
        chk("s12_done_e5", 32'(switch_done), 32'd1);
        step();

        // 2 -> 1 with dp_busy at edge 2: counter restarts.
        req_valid = 1'b1; req_id = 8'd1;
        step();
        req_valid = 1'b0;
        step();
        dp_busy = 1'b1;
        step();
        dp_busy = 1'b0;
        step();
        step();
        step();
        chk("s21_sel_e5", 32'(sel), 32'd3);
        chk("s21_stall_e5", 32'(stall), 32'd1);
        step();
        chk("s21_sel_e6", 32'(sel), 32'd0);
        chk("s21_stall_e6", 32'(stall), 32'd1);
        step();
        chk("s21_stall_e7", 32'(stall), 32'd0);
        chk("s21_done_e7", 32'(switch_done), 32'd1);
        step();

        // Back to cfg 2.
        req_valid = 1'b1; req_id = 8'd2;
        step();
        req_valid = 1'b0;
        wait_done("to2_timeout");
        step();

        // Unknown ID in RUN, then repeated ID.
        req_valid = 1'b1; req_id = 8'd7;
        step();
        req_valid = 1'b0;
        chk("r7_err", 32'(err), 32'd1);
        chk("r7_sel", 32'(sel), 32'd3);
        chk("r7_cfg_id", 32'(cfg_id), 32'd2);
        chk("r7_stall", 32'(stall), 32'd0);
        step();
        chk("r7_err_off", 32'(err), 32'd0);
        req_valid = 1'b1; req_id = 8'd2;
        step();
        req_valid = 1'b0;
        chk("rep_done", 32'(switch_done), 32'd1);
        chk("rep_stall", 32'(stall), 32'd0);
        chk("rep_ready", 32'(req_ready), 32'd1);
        step();
        chk("rep_done_off", 32'(switch_done), 32'd0);

        // 2 -> 1 and reset at edge 2 of the drain.
        req_valid = 1'b1; req_id = 8'd1;
        step();
        req_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_reset_vals("mid_rst");

        // Random phase checked by the scoreboard.
        for (int i = 0; i < 40; i++) begin
            int k;
            k = 0;
            while (!req_ready && k < 200) begin
                dp_busy = ($urandom_range(0, 7) == 0);
                step();
                k++;
            end
            chk("rnd_ready", 32'(req_ready), 32'd1);
            case ($urandom_range(0, 4))
                0, 1:    req_id = 8'd1;
                2, 3:    req_id = 8'd2;
                default: req_id = 8'($urandom_range(3, 255));
            endcase
            req_valid = 1'b1;
            dp_busy = ($urandom_range(0, 7) == 0);
            step();
            req_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                dp_busy = ($urandom_range(0, 7) == 0);
                step();
            end
        end
        dp_busy = 1'b0;
        repeat (20) step();
        chk("sb_left", 32'(sb.size()), 32'd0);
        chk("eq_left", 32'(eq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
